mapu_row_assembler: RTL and testbench

Upstream feeder for the Matrix APU data-plane input. Accepts a single-element stream, packs every three consecutive elements into one matrix row (elements 0, 1, 2), and buffers complete rows in a small row FIFO. It presents each row to the MAPU input port with a valid/ready handshake. It also tracks row position within the 3x3 matrix and counts completed matrices.

---
 rtl/mapu_row_assembler.sv | 133 +++++++++++++
 tb/tb_mapu_row_assembler.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/mapu_row_assembler.sv
// rtl/mapu_row_assembler.sv - packs an element stream into 3-element rows and buffers them for the MAPU
// Row FIFO kept as its own module; the head entry is read straight from registered storage.

module mapu_row_fifo #(
   parameter int WIDTH = 96,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             empty,
   output logic             full
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [CW-1:0]    count;

   function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign empty = (count == '0);
   assign full  = (count == CW'(DEPTH));
   assign head  = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= ptr_next(wr_ptr);
         end
         if (pop) rd_ptr <= ptr_next(rd_ptr);
         if (push && !pop)      count <= count + CW'(1);
         else if (pop && !push) count <= count - CW'(1);
      end
   end
endmodule

module mapu_row_assembler #(
   parameter int DATA_WIDTH = 32,
   parameter int ROW_DEPTH  = 2
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  i_en,
   input  logic                  i_clr,
   input  logic                  i_vld,
   input  logic [DATA_WIDTH-1:0] i_data,
   output logic                  o_rdy,
   output logic                  o_vld,
   output logic [DATA_WIDTH-1:0] o_r0,
   output logic [DATA_WIDTH-1:0] o_r1,
   output logic [DATA_WIDTH-1:0] o_r2,
   input  logic                  i_rdy,
   output logic [1:0]            o_row_idx,
   output logic [15:0]           o_mat_cnt
);
   logic [1:0]              ecnt;
   logic [DATA_WIDTH-1:0]   slot0;
   logic [DATA_WIDTH-1:0]   slot1;
   logic [1:0]              rcnt;
   logic [15:0]             mat_cnt;
   logic                    fifo_empty;
   logic                    fifo_full;
   logic [3*DATA_WIDTH-1:0] fifo_head;
   logic                    accept;
   logic                    push;
   logic                    pop;

   // Only a row-completing element needs FIFO space, so a full FIFO stalls just that one.
   assign o_rdy  = reset_n && i_en && !i_clr && !(ecnt == 2'd2 && fifo_full);
   assign accept = i_vld && o_rdy;
   assign push   = accept && (ecnt == 2'd2);
   assign o_vld  = !fifo_empty;
   assign pop    = o_vld && i_rdy;

   mapu_row_fifo #(
      .WIDTH(3 * DATA_WIDTH),
      .DEPTH(ROW_DEPTH)
   ) u_fifo (
      .clk      (clk),
      .reset_n  (reset_n),
      .push     (push),
      .push_data({i_data, slot1, slot0}),
      .pop      (pop),
      .head     (fifo_head),
      .empty    (fifo_empty),
      .full     (fifo_full)
   );

   assign o_r0      = fifo_head[DATA_WIDTH-1:0];
   assign o_r1      = fifo_head[2*DATA_WIDTH-1:DATA_WIDTH];
   assign o_r2      = fifo_head[3*DATA_WIDTH-1:2*DATA_WIDTH];
   assign o_row_idx = rcnt;
   assign o_mat_cnt = mat_cnt;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         ecnt    <= 2'd0;
         slot0   <= '0;
         slot1   <= '0;
         rcnt    <= 2'd0;
         mat_cnt <= 16'd0;
      end else begin
         if (i_clr) begin
            ecnt <= 2'd0;
         end else if (accept) begin
            case (ecnt)
               2'd0:    slot0 <= i_data;
               2'd1:    slot1 <= i_data;
               default: ;
            endcase
            ecnt <= (ecnt == 2'd2) ? 2'd0 : ecnt + 2'd1;
         end
         if (pop) begin
            rcnt <= (rcnt == 2'd2) ? 2'd0 : rcnt + 2'd1;
            if (rcnt == 2'd2) mat_cnt <= mat_cnt + 16'd1;
         end
      end
   end
endmodule

// File: tb/tb_mapu_row_assembler.sv
// tb/tb_mapu_row_assembler.sv - directed self-checking bench for mapu_row_assembler

module tb_mapu_row_assembler;
   logic        clk = 1'b0;
   logic        reset_n;
   logic        i_en;
   logic        i_clr;
   logic        i_vld;
   logic [31:0] i_data;
   logic        o_rdy;
   logic        o_vld;
   logic [31:0] o_r0;
   logic [31:0] o_r1;
   logic [31:0] o_r2;
   logic        i_rdy;
   logic [1:0]  o_row_idx;
   logic [15:0] o_mat_cnt;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   mapu_row_assembler #(.DATA_WIDTH(32), .ROW_DEPTH(2)) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .i_en     (i_en),
      .i_clr    (i_clr),
      .i_vld    (i_vld),
      .i_data   (i_data),
      .o_rdy    (o_rdy),
      .o_vld    (o_vld),
      .o_r0     (o_r0),
      .o_r1     (o_r1),
      .o_r2     (o_r2),
      .i_rdy    (i_rdy),
      .o_row_idx(o_row_idx),
      .o_mat_cnt(o_mat_cnt)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // inputs change 1 time unit after the rising edge, outputs sampled 1 unit later
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [31:0] d);
      i_vld  = 1'b1;
      i_data = d;
      #1;
      check("send_rdy", 32'(o_rdy), 32'd1);
      tick();
      i_vld = 1'b0;
   endtask

   task automatic check_row(input string tag, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] c, input logic [1:0] idx);
      check({tag, "_vld"}, 32'(o_vld), 32'd1);
      check({tag, "_r0"}, o_r0, a);
      check({tag, "_r1"}, o_r1, b);
      check({tag, "_r2"}, o_r2, c);
      check({tag, "_idx"}, 32'(o_row_idx), 32'(idx));
   endtask

   initial begin
      reset_n = 1'b0;
      i_en    = 1'b1;
      i_clr   = 1'b0;
      i_vld   = 1'b1;
      i_data  = 32'hDEAD;
      i_rdy   = 1'b1;

      // reset held with upstream pushing
      for (int i = 0; i < 4; i++) begin
         tick();
         check("rst_rdy", 32'(o_rdy), 32'd0);
         check("rst_vld", 32'(o_vld), 32'd0);
         check("rst_r0", o_r0, 32'd0);
         check("rst_r1", o_r1, 32'd0);
         check("rst_r2", o_r2, 32'd0);
         check("rst_mat", 32'(o_mat_cnt), 32'd0);
         check("rst_idx", 32'(o_row_idx), 32'd0);
      end
      i_vld   = 1'b0;
      reset_n = 1'b1;
      #1;

      // stream 1..9 with MAPU always ready
      for (int k = 1; k <= 9; k++) begin
         send(32'(k));
         if (k % 3 == 0) begin
            check_row("flow", 32'(k - 2), 32'(k - 1), 32'(k), 2'(k / 3 - 1));
            check("flow_mat", 32'(o_mat_cnt), 32'd0);
         end else if (k > 3 && k % 3 == 1) begin
            check("flow_popped", 32'(o_vld), 32'd0);
         end
      end
      tick();
      check("flow_empty", 32'(o_vld), 32'd0);
      check("flow_mat1", 32'(o_mat_cnt), 32'd1);
      check("flow_idx0", 32'(o_row_idx), 32'd0);

      // backpressure: FIFO fills, element 9 stalls
      i_rdy = 1'b0;
      for (int k = 1; k <= 8; k++) send(32'(k));
      i_vld  = 1'b1;
      i_data = 32'd9;
      #1;
      check("bp_rdy_low", 32'(o_rdy), 32'd0);
      check_row("bp_head", 32'd1, 32'd2, 32'd3, 2'd0);
      tick();
      check("bp_rdy_low2", 32'(o_rdy), 32'd0);
      check_row("bp_stable", 32'd1, 32'd2, 32'd3, 2'd0);
      i_rdy = 1'b1;
      #1;
      check("bp_no_comb", 32'(o_rdy), 32'd0);
      tick();
      i_rdy = 1'b0;
      #1;
      check("bp_rdy_back", 32'(o_rdy), 32'd1);
      check_row("bp_row2", 32'd4, 32'd5, 32'd6, 2'd1);
      tick();
      i_vld = 1'b0;
      i_rdy = 1'b1;
      #1;
      check_row("bp_drain2", 32'd4, 32'd5, 32'd6, 2'd1);
      tick();
      check_row("bp_drain3", 32'd7, 32'd8, 32'd9, 2'd2);
      tick();
      check("bp_empty", 32'(o_vld), 32'd0);
      check("bp_mat2", 32'(o_mat_cnt), 32'd2);

      // clear discards partial row, clr beats a valid element
      send(32'hA);
      send(32'hB);
      i_clr  = 1'b1;
      i_vld  = 1'b1;
      i_data = 32'hFF;
      #1;
      check("clr_rdy", 32'(o_rdy), 32'd0);
      tick();
      i_clr = 1'b0;
      i_vld = 1'b0;
      check("clr_novld", 32'(o_vld), 32'd0);
      send(32'hC);
      send(32'hD);
      check("clr_novld2", 32'(o_vld), 32'd0);
      send(32'hE);
      check_row("clr_row", 32'hC, 32'hD, 32'hE, 2'd0);
      check("clr_mat", 32'(o_mat_cnt), 32'd2);
      tick();
      check("clr_empty", 32'(o_vld), 32'd0);

      // enable gating while a buffered row drains
      i_rdy = 1'b0;
      send(32'h1);
      send(32'h2);
      send(32'h3);
      send(32'h5);
      i_rdy  = 1'b1;
      i_en   = 1'b0;
      i_vld  = 1'b1;
      i_data = 32'h99;
      #1;
      check_row("en_buf", 32'h1, 32'h2, 32'h3, 2'd1);
      for (int i = 0; i < 5; i++) begin
         check("en_rdy_low", 32'(o_rdy), 32'd0);
         tick();
         check("en_drained", 32'(o_vld), 32'd0);
      end
      check("en_idx", 32'(o_row_idx), 32'd2);
      i_en = 1'b1;
      send(32'h6);
      check("en_partial", 32'(o_vld), 32'd0);
      send(32'h7);
      check_row("en_row", 32'h5, 32'h6, 32'h7, 2'd2);
      tick();
      check("en_mat3", 32'(o_mat_cnt), 32'd3);
      check("en_idx0", 32'(o_row_idx), 32'd0);

      // reset mid-operation with one row buffered and ecnt=1
      i_rdy = 1'b0;
      send(32'h11);
      send(32'h12);
      send(32'h13);
      send(32'h14);
      check("mr_pre_vld", 32'(o_vld), 32'd1);
      reset_n = 1'b0;
      tick();
      check("mr_vld", 32'(o_vld), 32'd0);
      check("mr_r0", o_r0, 32'd0);
      check("mr_r1", o_r1, 32'd0);
      check("mr_r2", o_r2, 32'd0);
      check("mr_idx", 32'(o_row_idx), 32'd0);
      check("mr_mat", 32'(o_mat_cnt), 32'd0);
      reset_n = 1'b1;
      send(32'h21);
      send(32'h22);
      check("mr_partial", 32'(o_vld), 32'd0);
      send(32'h23);
      check_row("mr_row", 32'h21, 32'h22, 32'h23, 2'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
